// File: rtl/qcv_pkg.sv
// Shared integer-pipeline definitions: register-file geometry and the writeback entry.
package qcv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wdata;
  } wb_entry_t;

endpackage

// File: rtl/qcv_wb_fifo.sv
// Small synchronous FIFO of writeback entries; push while full and pop while empty are ignored.
module qcv_wb_fifo
  import qcv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               push_ok;
  logic               pop_ok;

  assign full_o  = (count == FULL_CNT);
  assign empty_o = (count == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/qcv_writeback_unit.sv
// Register-file write owner: merges ALU and LSU results, tracks pending loads, forwards the in-flight write.
module qcv_writeback_unit
  import qcv_pkg::*;
#(
  parameter int LSU_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]       alu_wdata_i,
  output logic                  alu_stall_o,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [REG_ADDR_W-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]       lsu_wdata_i,
  input  logic                  lsu_issue_i,
  input  logic [REG_ADDR_W-1:0] lsu_issue_rd_i,
  input  logic [REG_ADDR_W-1:0] raddr_a_i,
  input  logic [REG_ADDR_W-1:0] raddr_b_i,
  output logic                  busy_a_o,
  output logic                  busy_b_o,
  output logic                  fwd_a_o,
  output logic                  fwd_b_o,
  output logic [XLEN-1:0]       fwd_data_o,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]       rf_wdata_o,
  output logic                  err_o
);

  localparam int           NREGS      = 2 ** REG_ADDR_W;
  localparam logic [3:0]   STARVE_MAX = 4'(STARVE_LIMIT);

  wb_entry_t        fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             pop;
  logic             alu_take;
  logic [3:0]       starve_cnt;
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  assign lsu_ready_o = !fifo_full && !rst_i;
  assign fifo_push   = lsu_valid_i && lsu_ready_o;
  assign alu_stall_o = (starve_cnt == STARVE_MAX);
  assign alu_take    = alu_valid_i && !alu_stall_o;
  // The LSU head wins whenever the ALU is idle or has been forced to yield.
  assign pop         = !fifo_empty && (!alu_valid_i || alu_stall_o);

  qcv_wb_fifo #(.DEPTH(LSU_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i ('{rd: lsu_rd_i, wdata: lsu_wdata_i}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (lsu_issue_i && lsu_issue_rd_i != REG_ZERO) set_mask[lsu_issue_rd_i] = 1'b1;
    if (pop && fifo_head.rd != REG_ZERO)           clr_mask[fifo_head.rd]   = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend       <= '0;
      starve_cnt <= '0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= REG_ZERO;
      rf_wdata_o <= '0;
      err_o      <= 1'b0;
    end else begin
      // Applying the set after the clear makes a same-cycle re-issue keep the bit.
      pend <= (pend & ~clr_mask) | set_mask;

      if (pop || fifo_empty) starve_cnt <= '0;
      else                   starve_cnt <= starve_cnt + 1'b1;

      if (pop) begin
        rf_we_o    <= (fifo_head.rd != REG_ZERO);
        rf_waddr_o <= fifo_head.rd;
        rf_wdata_o <= fifo_head.wdata;
      end else if (alu_take) begin
        rf_we_o    <= (alu_rd_i != REG_ZERO);
        rf_waddr_o <= alu_rd_i;
        rf_wdata_o <= alu_wdata_i;
      end else begin
        rf_we_o    <= 1'b0;
      end

      if ((lsu_issue_i && lsu_issue_rd_i != REG_ZERO && pend[lsu_issue_rd_i]) ||
          (alu_valid_i && alu_stall_o))
        err_o <= 1'b1;
    end
  end

  assign busy_a_o   = (raddr_a_i != REG_ZERO) && pend[raddr_a_i];
  assign busy_b_o   = (raddr_b_i != REG_ZERO) && pend[raddr_b_i];
  assign fwd_a_o    = rf_we_o && (rf_waddr_o == raddr_a_i) && (raddr_a_i != REG_ZERO);
  assign fwd_b_o    = rf_we_o && (rf_waddr_o == raddr_b_i) && (raddr_b_i != REG_ZERO);
  assign fwd_data_o = rf_wdata_o;

endmodule

// File: tb/tb_qcv_writeback_unit.sv
// Directed bench for qcv_writeback_unit: reset, ALU/LSU writes, collision, scoreboard and error flag.
module tb_qcv_writeback_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_wdata_i;
  logic        alu_stall_o;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_issue_i;
  logic [4:0]  lsu_issue_rd_i;
  logic [4:0]  raddr_a_i;
  logic [4:0]  raddr_b_i;
  logic        busy_a_o;
  logic        busy_b_o;
  logic        fwd_a_o;
  logic        fwd_b_o;
  logic [31:0] fwd_data_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        err_o;

  int n_vec  = 0;
  int n_miss = 0;

  qcv_writeback_unit #(.LSU_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .alu_valid_i    (alu_valid_i),
    .alu_rd_i       (alu_rd_i),
    .alu_wdata_i    (alu_wdata_i),
    .alu_stall_o    (alu_stall_o),
    .lsu_valid_i    (lsu_valid_i),
    .lsu_ready_o    (lsu_ready_o),
    .lsu_rd_i       (lsu_rd_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_issue_i    (lsu_issue_i),
    .lsu_issue_rd_i (lsu_issue_rd_i),
    .raddr_a_i      (raddr_a_i),
    .raddr_b_i      (raddr_b_i),
    .busy_a_o       (busy_a_o),
    .busy_b_o       (busy_b_o),
    .fwd_a_o        (fwd_a_o),
    .fwd_b_o        (fwd_b_o),
    .fwd_data_o     (fwd_data_o),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs set afterwards belong to the next cycle.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_no_busy();
    for (int a = 0; a < 32; a++) begin
      raddr_a_i = 5'(a);
      #1;
      chk($sformatf("busy_a[%0d] after reset", a), 32'(busy_a_o), 32'd0);
    end
  endtask

  logic [6:0] stall_pat;
  logic [6:0] ready_pat;

  initial begin
    rst_i = 1'b1;
    alu_valid_i = 1'b0; alu_rd_i = '0; alu_wdata_i = '0;
    lsu_valid_i = 1'b0; lsu_rd_i = '0; lsu_wdata_i = '0;
    lsu_issue_i = 1'b0; lsu_issue_rd_i = '0;
    raddr_a_i = '0; raddr_b_i = '0;

    // Reset state
    tick(); tick();
    chk("rst rf_we", 32'(rf_we_o), 32'd0);
    chk("rst lsu_ready", 32'(lsu_ready_o), 32'd0);
    chk("rst alu_stall", 32'(alu_stall_o), 32'd0);
    chk("rst err", 32'(err_o), 32'd0);
    rst_i = 1'b0;
    tick();
    chk("post-rst lsu_ready", 32'(lsu_ready_o), 32'd1);
    check_no_busy();

    // ALU write to x5
    alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_wdata_i = 32'h0000_1234; raddr_a_i = 5'd5;
    tick();
    chk("alu rf_we", 32'(rf_we_o), 32'd1);
    chk("alu rf_waddr", 32'(rf_waddr_o), 32'd5);
    chk("alu rf_wdata", rf_wdata_o, 32'h0000_1234);
    chk("alu fwd_a", 32'(fwd_a_o), 32'd1);
    chk("alu fwd_data", fwd_data_o, 32'h0000_1234);
    alu_rd_i = 5'd0; alu_wdata_i = 32'h0000_0055;
    tick();
    chk("alu rd0 rf_we", 32'(rf_we_o), 32'd0);
    chk("alu rd0 fwd_a", 32'(fwd_a_o), 32'd0);
    alu_valid_i = 1'b0;
    tick();
    chk("idle rf_we", 32'(rf_we_o), 32'd0);

    // LSU load to x7
    lsu_issue_i = 1'b1; lsu_issue_rd_i = 5'd7; raddr_a_i = 5'd7;
    tick();
    lsu_issue_i = 1'b0;
    #1;
    chk("lsu busy after issue", 32'(busy_a_o), 32'd1);
    tick();
    chk("lsu busy waiting", 32'(busy_a_o), 32'd1);
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_wdata_i = 32'hDEAD_BEEF;
    #1;
    chk("lsu ready N", 32'(lsu_ready_o), 32'd1);
    tick();
    lsu_valid_i = 1'b0;
    #1;
    chk("lsu busy N+1", 32'(busy_a_o), 32'd1);
    chk("lsu rf_we N+1", 32'(rf_we_o), 32'd0);
    tick();
    chk("lsu rf_we N+2", 32'(rf_we_o), 32'd1);
    chk("lsu rf_waddr N+2", 32'(rf_waddr_o), 32'd7);
    chk("lsu rf_wdata N+2", rf_wdata_o, 32'hDEAD_BEEF);
    chk("lsu busy N+2", 32'(busy_a_o), 32'd0);
    chk("lsu fwd_a N+2", 32'(fwd_a_o), 32'd1);
    tick();
    chk("lsu rf_we N+3", 32'(rf_we_o), 32'd0);

    // Collision: ALU every cycle, LSU A/B/C (x20/x21/x22) offered from cycle 0
    stall_pat = 7'b0100000;
    ready_pat = 7'b1000011;
    for (int k = 0; k < 7; k++) begin
      alu_valid_i = !stall_pat[k];
      alu_rd_i    = 5'(10 + k);
      alu_wdata_i = 32'hA000_0000 + 32'(k);
      lsu_valid_i = 1'b1;
      lsu_rd_i    = (k == 0) ? 5'd20 : (k == 1) ? 5'd21 : 5'd22;
      lsu_wdata_i = (k == 0) ? 32'hB000_0014 : (k == 1) ? 32'hB000_0015 : 32'hB000_0016;
      #1;
      chk($sformatf("col stall c%0d", k), 32'(alu_stall_o), 32'(stall_pat[k]));
      chk($sformatf("col ready c%0d", k), 32'(lsu_ready_o), 32'(ready_pat[k]));
      tick();
      chk($sformatf("col rf_we c%0d", k), 32'(rf_we_o), 32'd1);
      if (k == 5) begin
        chk("col head rd", 32'(rf_waddr_o), 32'd20);
        chk("col head data", rf_wdata_o, 32'hB000_0014);
      end else begin
        chk($sformatf("col alu rd c%0d", k), 32'(rf_waddr_o), 32'(10 + k));
        chk($sformatf("col alu data c%0d", k), rf_wdata_o, 32'hA000_0000 + 32'(k));
      end
    end
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    tick();
    chk("drain B rd", 32'(rf_waddr_o), 32'd21);
    chk("drain B data", rf_wdata_o, 32'hB000_0015);
    tick();
    chk("drain C rd", 32'(rf_waddr_o), 32'd22);
    chk("drain C data", rf_wdata_o, 32'hB000_0016);
    chk("col err", 32'(err_o), 32'd0);
    tick();

    // Same-cycle set/clear on x9
    lsu_issue_i = 1'b1; lsu_issue_rd_i = 5'd9; raddr_a_i = 5'd9;
    tick();
    lsu_issue_i = 1'b0;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_wdata_i = 32'h0000_0099;
    tick();
    lsu_valid_i = 1'b0;
    lsu_issue_i = 1'b1; lsu_issue_rd_i = 5'd9;
    #1;
    chk("setclr busy before", 32'(busy_a_o), 32'd1);
    tick();
    lsu_issue_i = 1'b0;
    #1;
    chk("setclr rf_waddr", 32'(rf_waddr_o), 32'd9);
    chk("setclr busy after", 32'(busy_a_o), 32'd1);
    chk("setclr err (re-issue while pending)", 32'(err_o), 32'd1);

    // Asynchronous reset mid-write with an LSU result queued
    alu_valid_i = 1'b1; alu_rd_i = 5'd6; alu_wdata_i = 32'h0000_0066;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd8; lsu_wdata_i = 32'h0000_0088;
    raddr_a_i = 5'd6;
    tick();
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    chk("pre-rst rf_we", 32'(rf_we_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("async rst rf_we", 32'(rf_we_o), 32'd0);
    chk("async rst rf_waddr", 32'(rf_waddr_o), 32'd0);
    chk("async rst rf_wdata", rf_wdata_o, 32'd0);
    chk("async rst fwd_a", 32'(fwd_a_o), 32'd0);
    chk("async rst lsu_ready", 32'(lsu_ready_o), 32'd0);
    chk("async rst err", 32'(err_o), 32'd0);
    tick();
    rst_i = 1'b0;
    tick(); tick();
    chk("discarded queue rf_we", 32'(rf_we_o), 32'd0);
    chk("post-rst2 lsu_ready", 32'(lsu_ready_o), 32'd1);
    check_no_busy();

    // Error: double issue to x3
    lsu_issue_i = 1'b1; lsu_issue_rd_i = 5'd3;
    tick();
    chk("err after first issue", 32'(err_o), 32'd0);
    tick();
    lsu_issue_i = 1'b0;
    chk("err double issue", 32'(err_o), 32'd1);
    tick(); tick(); tick();
    chk("err sticky", 32'(err_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    chk("err cleared by reset", 32'(err_o), 32'd0);

    // Error: ALU valid held through the forced stall
    for (int k = 0; k < 5; k++) begin
      alu_valid_i = 1'b1; alu_rd_i = 5'd11; alu_wdata_i = 32'hC000_0000 + 32'(k);
      lsu_valid_i = (k == 0); lsu_rd_i = 5'd4; lsu_wdata_i = 32'h0000_0444;
      tick();
    end
    lsu_valid_i = 1'b0;
    chk("stall before violation", 32'(alu_stall_o), 32'd1);
    chk("err before violation", 32'(err_o), 32'd0);
    tick();
    alu_valid_i = 1'b0;
    chk("err alu during stall", 32'(err_o), 32'd1);
    chk("stalled cycle writes LSU rd", 32'(rf_waddr_o), 32'd4);
    chk("stalled cycle writes LSU data", rf_wdata_o, 32'h0000_0444);
    tick();
    chk("err still sticky", 32'(err_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/qcv_writeback_unit.md
# qcv_writeback_unit

Single write-side owner of the integer register file. It merges results from the single-cycle ALU path and the variable-latency LSU path into one registered write port (rd address, data, enable) that drives the register file. It tracks outstanding LSU destinations in a scoreboard so issue logic can detect RAW hazards. It also exposes a forwarding path covering the cycle between a write being presented and the register file updating.

## Interface
- `LSU_DEPTH`, default 2: LSU result FIFO depth; allowed values ≥2, power of two.
- `STARVE_LIMIT`, default 4: consecutive cycles the FIFO head may be blocked by the ALU before ALU stall is forced; allowed range 1..15.
- `clk_i` in, 1: the single clock.
- `rst_i` in, 1: reset, asynchronous, active-high.
- `alu_valid_i` in, 1: ALU result valid; always accepted unless `alu_stall_o` is high.
- `alu_rd_i` in, 5: ALU destination register.
- `alu_wdata_i` in, 32: ALU result.
- `alu_stall_o` out, 1: upstream must hold the ALU result (drive `alu_valid_i` low).
- `lsu_valid_i` in, 1: LSU result valid.
- `lsu_ready_o` out, 1: FIFO can accept an LSU result.
- `lsu_rd_i` in, 5: LSU destination register.
- `lsu_wdata_i` in, 32: LSU load data.
- `lsu_issue_i` in, 1: an LSU op was issued this cycle.
- `lsu_issue_rd_i` in, 5: destination of the issued LSU op.
- `raddr_a_i` / `raddr_b_i` in, 5 each: rs1/rs2 being read by decode.
- `busy_a_o` / `busy_b_o` out, 1 each: the source register has an outstanding LSU write.
- `fwd_a_o` / `fwd_b_o` out, 1 each: the source matches the write currently presented.
- `fwd_data_o` out, 32: the data currently presented (equal to `rf_wdata_o`).
- `rf_we_o` out, 1: register file write enable.
- `rf_waddr_o` out, 5: register file write address.
- `rf_wdata_o` out, 32: register file write data.
- `err_o` out, 1: sticky protocol-error flag.

## Operation
- **LSU FIFO**
  - A push happens on `lsu_valid_i && lsu_ready_o`.
  - `lsu_ready_o = !full && !rst_i`.
  - No push is allowed while full, even if a pop occurs in the same cycle.
- **Selection, each cycle**
  - pop = FIFO non-empty && (!alu_valid_i || alu_stall_o).
  - If pop, the writeback register loads the FIFO head.
  - Otherwise, if `alu_valid_i && !alu_stall_o`, it loads the ALU result.
  - Otherwise `rf_we_o` goes to 0 next cycle.
- **rd = 0**: the result is consumed (popped or accepted) but loaded with `rf_we_o` = 0.
- **Starvation counter** (4 bits)
  - Clears on pop or when the FIFO is empty.
  - Increments when the FIFO is non-empty and not popped.
  - `alu_stall_o` is high when the counter equals `STARVE_LIMIT`. It drops the cycle after the pop.
- **Scoreboard** `pend[31:1]`
  - `lsu_issue_i` with rd ≠ 0 sets `pend[rd]`.
  - A pop of an entry with rd ≠ 0 clears `pend[rd]`.
  - If a set and a clear hit the same rd in the same cycle, the set wins.
- **Busy**: `busy_x_o = raddr_x ≠ 0 && pend[raddr_x]`.
- **Forward**: `fwd_x_o = rf_we_o && rf_waddr_o == raddr_x && raddr_x ≠ 0`.
- **err_o** sets on either of:
  - `lsu_issue_i` to an rd already pending (the bit stays set);
  - `alu_valid_i` while `alu_stall_o` (that ALU result is dropped).
  - It clears only on reset.
- **Reset** clears the FIFO, scoreboard, counter and all outputs. All outputs read 0 during reset, and `lsu_ready_o` is 1 after release. Reset mid-operation discards queued results without writing them.

## Timing
- **ALU result**, valid in cycle N: `rf_*_o` presents it in N+1, and the register file updates at the edge ending N+1.
- **LSU result**, pushed in N with no ALU in N+1: popped in N+1, presented in N+2.
  - `busy_x_o` falls in N+2, i.e. from the same edge that presents the result.
  - `fwd_x_o` is high in N+2, covering the read hole.
- **Busy/fwd**: combinational from `raddr_x_i` and state, with no added latency.
- **Back-to-back**: one write per cycle. Sustained throughput is 1 result/cycle total across both sources.

## Structure
- Shared package `qcv_pkg`:
  - `REG_ADDR_W` = 5, `XLEN` = 32;
  - a writeback-entry struct {rd, wdata};
  - `REG_ZERO` = 5'd0.
- Sub-module `qcv_wb_fifo`: parameterised-depth synchronous FIFO with push/pop/full/empty, holding wb entries.
- The top level holds the selection logic, starvation counter, scoreboard and output register.

## Test plan
- **Reset**: assert `rst_i` asynchronously mid-write.
  - All outputs go to 0 immediately.
  - After release, `lsu_ready_o` = 1 and `busy_a_o` = 0 for every address.
- **ALU write**: `alu_valid_i`, rd=5, data 0x0000_1234 in N.
  - In N+1: `rf_we_o` = 1, `rf_waddr_o` = 5, `rf_wdata_o` = 0x1234.
  - With `raddr_a_i` = 5: `fwd_a_o` = 1.
  - rd=0 instead gives `rf_we_o` = 0.
- **LSU path**: issue rd=7, then result 0xDEAD_BEEF pushed in N with the ALU idle.
  - `busy_a_o` = 1 for address 7 from the issue cycle through N+1.
  - In N+2: write presented, `busy_a_o` = 0, `fwd_a_o` = 1.
- **Collision/full**: ALU valid every cycle, then 3 LSU results offered with `STARVE_LIMIT` = 4.
  - `lsu_ready_o` falls after 2 pushes.
  - The ALU writes uninterrupted until `alu_stall_o` rises on the 4th blocked cycle.
  - The LSU head is then written, and the stall drops one cycle later.
- **Same-cycle set/clear**: pop rd=9 while issuing rd=9 → `pend[9]` stays 1 and `busy` stays 1.
- **Errors**: issue rd=3 twice while pending, or `alu_valid_i` during `alu_stall_o` → `err_o` = 1 and stays 1 until `rst_i`.
